keypad_debounce: RTL and testbench

//  Front-end input conditioner upstream of the microwave top level. It synchronises and debounces
//  the raw 10-key decimal keypad and the startn/stopn/clearn pushbuttons. It emits exactly one
//  1-cycle one-hot pulse per accepted keypress on key_pulse, which feeds the microwave keypad input.
//  It also emits clean, glitch-free active-low buttons.

---
 rtl/keypad_debounce_pkg.sv | 18 +
 rtl/keypad_debounce_cell.sv | 41 ++++
 rtl/keypad_debounce.sv | 130 +++++++++++++
 tb/tb_keypad_debounce.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_debounce_pkg.sv
// Shared types and constants for the keypad / pushbutton input conditioner.
package keypad_debounce_pkg;

    localparam int unsigned NUM_KEYS             = 10;
    localparam int unsigned DEBOUNCE_CYC_DEFAULT = 50000;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
    endfunction

endpackage

// File: rtl/keypad_debounce_cell.sv
// Single-bit debouncer: 2-FF synchroniser, stability counter and registered output
// with a configurable reset level.
module keypad_debounce_cell
    import keypad_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned CNT_W        = 16,
    parameter logic        RST_VAL      = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;

    // NOTE: all state here is sequential, so every assignment is non-blocking; blocking
    // assignments would let sync[1] see this cycle's sync[0] and collapse the synchroniser.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync  <= {2{RST_VAL}};
            cnt   <= '0;
            level <= RST_VAL;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_debounce.sv
// Keypad and pushbutton conditioner: one-hot key pulses plus debounced active-low buttons.
// Define KEY_REPEAT_EN to enable auto-repeat of a held key.
module keypad_debounce
    import keypad_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC   = DEBOUNCE_CYC_DEFAULT,
    parameter int unsigned CNT_W          = 16
`ifdef KEY_REPEAT_EN
    , parameter int unsigned REPEAT_DLY_CYC = 60000
    , parameter int unsigned REPEAT_PER_CYC = 20000
`endif
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] keypad_raw,
    input  logic                startn_raw,
    input  logic                stopn_raw,
    input  logic                clearn_raw,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic                key_held,
    output logic                startn,
    output logic                stopn,
    output logic                clearn
);

    // The state-entry sample counts as the first stable cycle, hence the -2.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 2);

    logic [NUM_KEYS-1:0] key_s1;
    logic [NUM_KEYS-1:0] k;
    logic [NUM_KEYS-1:0] code;
    key_state_t          state;
    logic [CNT_W-1:0]    cnt;

`ifdef KEY_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_DLY_LAST = CNT_W'(REPEAT_DLY_CYC - 1);
    localparam logic [CNT_W-1:0] RPT_PER_LAST = CNT_W'(REPEAT_PER_CYC - 1);

    logic [CNT_W-1:0] rpt_cnt;
    logic             rpt_phase;
    logic [CNT_W-1:0] rpt_last;

    assign rpt_last = rpt_phase ? RPT_PER_LAST : RPT_DLY_LAST;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_s1    <= '0;
            k         <= '0;
            code      <= '0;
            state     <= IDLE;
            cnt       <= '0;
            key_pulse <= '0;
            key_held  <= 1'b0;
`ifdef KEY_REPEAT_EN
            rpt_cnt   <= '0;
            rpt_phase <= 1'b0;
`endif
        end else begin
            key_s1    <= keypad_raw;
            k         <= key_s1;
            key_pulse <= '0;
            case (state)
                IDLE: begin
                    if (is_one_hot(k)) begin
                        code  <= k;
                        cnt   <= '0;
                        state <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (k != code) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state     <= PRESSED;
                        key_pulse <= code;
                        key_held  <= 1'b1;
`ifdef KEY_REPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (k == '0) begin
                        cnt   <= '0;
                        state <= RELEASE;
                    end
`ifdef KEY_REPEAT_EN
                    else if (rpt_cnt == rpt_last) begin
                        key_pulse <= code;
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b1;
                    end else begin
                        rpt_cnt <= rpt_cnt + CNT_W'(1);
                    end
`endif
                end
                RELEASE: begin
                    if (k != '0) begin
                        state <= PRESSED;
`ifdef KEY_REPEAT_EN
                        rpt_cnt   <= '0;
                        rpt_phase <= 1'b0;
`endif
                    end else if (cnt == DB_LAST) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    keypad_debounce_cell #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W), .RST_VAL(1'b1)) u_start (
        .clk(clk), .resetn(resetn), .raw(startn_raw), .level(startn)
    );
    keypad_debounce_cell #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W), .RST_VAL(1'b1)) u_stop (
        .clk(clk), .resetn(resetn), .raw(stopn_raw), .level(stopn)
    );
    keypad_debounce_cell #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W), .RST_VAL(1'b1)) u_clear (
        .clk(clk), .resetn(resetn), .raw(clearn_raw), .level(clearn)
    );

endmodule

// File: tb/tb_keypad_debounce.sv
// Self-checking bench for keypad_debounce: directed scenarios plus randomized key episodes
// and button traffic checked against timing rules computed from the raw stimulus.
module tb_keypad_debounce;

    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int PER = 5;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] keypad_raw = '0;
    logic       startn_raw = 1'b1;
    logic       stopn_raw  = 1'b1;
    logic       clearn_raw = 1'b1;
    logic [9:0] key_pulse;
    logic       key_held;
    logic       startn, stopn, clearn;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_pulse = -10;

    int         pulse_cyc[$];
    logic [9:0] pulse_val[$];
    int         exp_cyc[$];
    logic [9:0] exp_val[$];

    bit         btn_chk = 1'b0;
    logic [2:0] bh[$];
    logic [2:0] btn_exp = 3'b111;
    bit         keys_done = 1'b0;

    keypad_debounce #(
        .DEBOUNCE_CYC(DB),
        .CNT_W(16)
`ifdef KEY_REPEAT_EN
        , .REPEAT_DLY_CYC(DLY)
        , .REPEAT_PER_CYC(PER)
`endif
    ) dut (
        .clk(clk), .resetn(resetn), .keypad_raw(keypad_raw),
        .startn_raw(startn_raw), .stopn_raw(stopn_raw), .clearn_raw(clearn_raw),
        .key_pulse(key_pulse), .key_held(key_held),
        .startn(startn), .stopn(stopn), .clearn(clearn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse log plus per-cycle button model: an output flips once the four raw values
    // delivered through the 2-cycle synchroniser all disagree with it.
    always @(negedge clk) begin
        if (resetn && key_pulse !== '0) begin
            total++;
            if (!$onehot(key_pulse)) begin
                bad++;
                $display("FAIL pulse_onehot cyc=%0d got=%h", cyc, key_pulse);
            end
            total++;
            if (cyc == last_pulse + 1) begin
                bad++;
                $display("FAIL pulse_back_to_back cyc=%0d prev=%0d", cyc, last_pulse);
            end
            last_pulse = cyc;
            pulse_cyc.push_back(cyc);
            pulse_val.push_back(key_pulse);
        end
        if (btn_chk) begin
            bh.push_back({startn_raw, stopn_raw, clearn_raw});
            if (bh.size() > 7) void'(bh.pop_front());
            for (int b = 0; b < 3; b++) begin
                bit flip;
                flip = 1'b1;
                for (int d = 3; d <= 6; d++)
                    if (bh[6-d][b] == btn_exp[b]) flip = 1'b0;
                if (flip) btn_exp[b] = ~btn_exp[b];
            end
            total++;
            if ({startn, stopn, clearn} !== btn_exp) begin
                bad++;
                $display("FAIL buttons cyc=%0d got=%b want=%b", cyc, {startn, stopn, clearn}, btn_exp);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected pulses for a clean hold of `hold` cycles starting at cycle `start`.
    task automatic add_expected(input int start, input int hold, input logic [9:0] code);
        int t;
        t = start + 2 + DB;
        exp_cyc.push_back(t);
        exp_val.push_back(code);
`ifdef KEY_REPEAT_EN
        t = t + DLY;
        while (t <= start + hold + 2) begin
            exp_cyc.push_back(t);
            exp_val.push_back(code);
            t = t + PER;
        end
`endif
    endtask

    task automatic clear_logs();
        pulse_cyc.delete();
        pulse_val.delete();
        exp_cyc.delete();
        exp_val.delete();
    endtask

    task automatic test_reset();
        tick(2);
        total++;
        if ({key_pulse, key_held, startn, stopn, clearn} !== {10'h000, 1'b0, 3'b111}) begin
            bad++;
            $display("FAIL reset_init got=%h/%b/%b want=000/0/111", key_pulse, key_held, {startn, stopn, clearn});
        end
        resetn = 1'b1;
        tick(3);
        keypad_raw = 10'h010;
        stopn_raw  = 1'b0;
        tick(10);
        total++;
        if ({key_held, stopn} !== 2'b10) begin
            bad++;
            $display("FAIL reset_pre held/stopn got=%b want=10", {key_held, stopn});
        end
        #3 resetn = 1'b0;
        #1;
        total++;
        if ({key_pulse, key_held, startn, stopn, clearn} !== {10'h000, 1'b0, 3'b111}) begin
            bad++;
            $display("FAIL reset_async got=%h/%b/%b want=000/0/111", key_pulse, key_held, {startn, stopn, clearn});
        end
        tick(1);
        keypad_raw = '0;
        stopn_raw  = 1'b1;
        resetn     = 1'b1;
        tick(10);
        clear_logs();
        keypad_raw = 10'h040;
        tick(3);
        #2 resetn = 1'b0;
        keypad_raw = '0;
        tick(2);
        resetn = 1'b1;
        tick(12);
        total++;
        if (pulse_cyc.size() != 0 || key_held !== 1'b0) begin
            bad++;
            $display("FAIL reset_discard pulses=%0d held=%b want=0/0", pulse_cyc.size(), key_held);
        end
    endtask

    task automatic test_clean_press();
        int p, r;
        clear_logs();
        p = cyc;
        keypad_raw = 10'h008;
        add_expected(p, 20, 10'h008);
        tick(5);
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL clean_held_early got=%b want=0", key_held); end
        tick(1);
        total++;
        if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held_rise got=%b want=1", key_held); end
        tick(14);
        r = cyc;
        keypad_raw = '0;
        tick(5);
        total++;
        if (key_held !== 1'b1) begin bad++; $display("FAIL clean_held_release got=%b want=1 at +%0d", key_held, cyc - r); end
        tick(1);
        total++;
        if (key_held !== 1'b0) begin bad++; $display("FAIL clean_held_fall got=%b want=0 at +%0d", key_held, cyc - r); end
        tick(6);
        total++;
        if (pulse_cyc.size() != exp_cyc.size()) begin
            bad++;
            $display("FAIL clean_count got=%0d want=%0d", pulse_cyc.size(), exp_cyc.size());
        end
        foreach (exp_cyc[i]) if (i < pulse_cyc.size()) begin
            total++;
            if (pulse_cyc[i] != exp_cyc[i] || pulse_val[i] !== exp_val[i]) begin
                bad++;
                $display("FAIL clean_pulse%0d got=%0d/%h want=%0d/%h", i, pulse_cyc[i], pulse_val[i], exp_cyc[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_bounce();
        int p;
        clear_logs();
        repeat (3) begin
            keypad_raw = 10'h020;
            tick(3);
            keypad_raw = '0;
            tick(1);
        end
        p = cyc;
        keypad_raw = 10'h020;
        add_expected(p, 10, 10'h020);
        tick(10);
        keypad_raw = '0;
        tick(12);
        total++;
        if (pulse_cyc.size() != exp_cyc.size()) begin
            bad++;
            $display("FAIL bounce_count got=%0d want=%0d", pulse_cyc.size(), exp_cyc.size());
        end
        foreach (exp_cyc[i]) if (i < pulse_cyc.size()) begin
            total++;
            if (pulse_cyc[i] != exp_cyc[i] || pulse_val[i] !== exp_val[i]) begin
                bad++;
                $display("FAIL bounce_pulse%0d got=%0d/%h want=%0d/%h", i, pulse_cyc[i], pulse_val[i], exp_cyc[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_multi_key();
        int p;
        clear_logs();
        keypad_raw = 10'h006;
        tick(10);
        keypad_raw = '0;
        tick(10);
        total++;
        if (pulse_cyc.size() != 0) begin
            bad++;
            $display("FAIL multi_same_cycle got=%0d pulses want=0", pulse_cyc.size());
        end
        p = cyc;
        keypad_raw = 10'h002;
        add_expected(p, 14, 10'h002);
        tick(8);
        keypad_raw = 10'h006;
        tick(6);
        keypad_raw = '0;
        tick(12);
        total++;
        if (pulse_cyc.size() != exp_cyc.size()) begin
            bad++;
            $display("FAIL multi_count got=%0d want=%0d", pulse_cyc.size(), exp_cyc.size());
        end
        foreach (exp_cyc[i]) if (i < pulse_cyc.size()) begin
            total++;
            if (pulse_cyc[i] != exp_cyc[i] || pulse_val[i] !== exp_val[i]) begin
                bad++;
                $display("FAIL multi_pulse%0d got=%0d/%h want=%0d/%h", i, pulse_cyc[i], pulse_val[i], exp_cyc[i], exp_val[i]);
            end
        end
    endtask

    task automatic test_button_glitch();
        stopn_raw = 1'b0;
        tick(3);
        stopn_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if (stopn !== 1'b1) begin bad++; $display("FAIL glitch_short cyc=%0d got=%b want=1", cyc, stopn); end
            tick(1);
        end
        stopn_raw = 1'b0;
        tick(5);
        total++;
        if (stopn !== 1'b1) begin bad++; $display("FAIL glitch_long_early got=%b want=1", stopn); end
        tick(1);
        total++;
        if (stopn !== 1'b0) begin bad++; $display("FAIL glitch_long_fall got=%b want=0", stopn); end
        tick(2);
        stopn_raw = 1'b1;
        tick(5);
        total++;
        if (stopn !== 1'b0) begin bad++; $display("FAIL glitch_long_hold got=%b want=0", stopn); end
        tick(1);
        total++;
        if (stopn !== 1'b1) begin bad++; $display("FAIL glitch_long_rise got=%b want=1", stopn); end
        tick(8);
    endtask

    task automatic test_repeat();
        int p;
        clear_logs();
        p = cyc;
        keypad_raw = 10'h001;
        add_expected(p, 40, 10'h001);
        tick(40);
        keypad_raw = '0;
        tick(12);
        total++;
        if (pulse_cyc.size() != exp_cyc.size()) begin
            bad++;
            $display("FAIL repeat_count got=%0d want=%0d", pulse_cyc.size(), exp_cyc.size());
        end
        foreach (exp_cyc[i]) if (i < pulse_cyc.size()) begin
            total++;
            if (pulse_cyc[i] != exp_cyc[i] || pulse_val[i] !== exp_val[i]) begin
                bad++;
                $display("FAIL repeat_pulse%0d got=+%0d/%h want=+%0d/%h", i, pulse_cyc[i] - p, pulse_val[i], exp_cyc[i] - p, exp_val[i]);
            end
        end
    endtask

    task automatic key_episodes();
        for (int e = 0; e < 16; e++) begin
            int key, other, hold, start;
            logic [9:0] v;
            key = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) begin
                other = (key + $urandom_range(1, 9)) % 10;
                v = 10'($urandom) | (10'h001 << key) | (10'h001 << other);
                keypad_raw = v;
                tick($urandom_range(4, 10));
            end else begin
                repeat ($urandom_range(0, 3)) begin
                    keypad_raw = 10'h001 << key;
                    tick($urandom_range(1, 3));
                    keypad_raw = '0;
                    tick($urandom_range(1, 3));
                end
                start = cyc;
                hold  = $urandom_range(4, 12);
                keypad_raw = 10'h001 << key;
                add_expected(start, hold, 10'h001 << key);
                if (hold >= 6 && $urandom_range(0, 1) == 1) begin
                    tick(4);
                    other = (key + $urandom_range(1, 9)) % 10;
                    keypad_raw = (10'h001 << key) | (10'h001 << other);
                    tick(hold - 4);
                end else begin
                    tick(hold);
                end
                repeat ($urandom_range(0, 2)) begin
                    keypad_raw = '0;
                    tick($urandom_range(1, 3));
                    keypad_raw = 10'h001 << key;
                    tick($urandom_range(1, 3));
                end
            end
            keypad_raw = '0;
            tick(12);
        end
        keys_done = 1'b1;
    endtask

    task automatic button_traffic();
        while (!keys_done) begin
            {startn_raw, stopn_raw, clearn_raw} = 3'($urandom_range(0, 7));
            tick($urandom_range(1, 8));
        end
        {startn_raw, stopn_raw, clearn_raw} = 3'b111;
    endtask

    task automatic test_random();
        clear_logs();
        bh.delete();
        repeat (7) bh.push_back(3'b111);
        btn_exp = 3'b111;
        btn_chk = 1'b1;
        fork
            key_episodes();
            button_traffic();
        join
        tick(10);
        btn_chk = 1'b0;
        total++;
        if (pulse_cyc.size() != exp_cyc.size()) begin
            bad++;
            $display("FAIL random_count got=%0d want=%0d", pulse_cyc.size(), exp_cyc.size());
        end
        foreach (exp_cyc[i]) if (i < pulse_cyc.size()) begin
            total++;
            if (pulse_cyc[i] != exp_cyc[i] || pulse_val[i] !== exp_val[i]) begin
                bad++;
                $display("FAIL random_pulse%0d got=%0d/%h want=%0d/%h", i, pulse_cyc[i], pulse_val[i], exp_cyc[i], exp_val[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_button_glitch();
        test_repeat();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
